axi_stream_packetizer: RTL

Upstream feeder for the single-transfer AXI-stream writer stage (enable/idle handshake, tkeep/tdest/tlast side-band). It takes a packet command (byte length and destination) plus a plain valid/ready word stream. It slices the packet into BUS_WIDTH beats and issues each beat to the writer as one enable pulse, generating the tkeep, tdest and tlast values. It is used in the FINN-to-Galapagos bridge to frame raw accelerator output into Galapagos packets.

---
 rtl/axi_stream_packetizer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_stream_packetizer.sv
// ---------------------------------------------------------------------------
// axi_stream_packetizer
//
// Purpose:
//   Frames a raw valid/ready word stream into packets for the single-transfer
//   AXI-stream writer stage. A packet command (byte length + destination)
//   is split into BUS_WIDTH-wide beats. Each beat is handed to the writer
//   as a one-cycle enable pulse, together with LSB-aligned tkeep, the
//   latched tdest, and tlast on the final beat. Only one beat is in flight
//   at a time: fetch a word, issue it, then wait for the writer to go idle.
//
// Ports:
//   i_clk        clock
//   i_aresetn    asynchronous active-low reset
//   i_start      command strobe, sampled only while o_busy = 0
//   i_len_bytes  packet length in bytes, latched on an accepted start
//   i_dest       destination, latched on an accepted start
//   o_busy       high from an accepted start until the packet completes
//   o_done       one-cycle completion pulse
//   i_in_valid   source word valid
//   o_in_ready   packetizer can take a source word
//   i_in_data    source word, byte 0 = bits [7:0]
//   o_wr_enable  one-cycle transfer pulse to the writer
//   i_wr_idle    writer idle / ready for a new transfer
//   o_wr_data    beat data
//   o_wr_tkeep   beat byte enables
//   o_wr_tdest   beat destination
//   o_wr_tlast   final beat of the packet
// ---------------------------------------------------------------------------
module axi_stream_packetizer #(
    parameter int BUS_WIDTH = 16,
    parameter int LEN_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_aresetn,
    input  logic                   i_start,
    input  logic [LEN_WIDTH-1:0]   i_len_bytes,
    input  logic [31:0]            i_dest,
    output logic                   o_busy,
    output logic                   o_done,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [BUS_WIDTH-1:0]   i_in_data,
    output logic                   o_wr_enable,
    input  logic                   i_wr_idle,
    output logic [BUS_WIDTH-1:0]   o_wr_data,
    output logic [BUS_WIDTH/8-1:0] o_wr_tkeep,
    output logic [31:0]            o_wr_tdest,
    output logic                   o_wr_tlast
);

    localparam int                   BYTES   = BUS_WIDTH / 8;
    localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;
    logic                   zero_pend_q, zero_pend_d;
    logic                   guard_q, guard_d;
    logic                   busy_d;
    logic                   done_d;
    logic                   in_ready_d;
    logic                   enable_d;
    logic [BUS_WIDTH-1:0]   data_d;
    logic [BYTES-1:0]       keep_d;
    logic [31:0]            dest_d;
    logic                   last_d;
    logic [BYTES-1:0]       keep_next;
    logic [1:0]             rst_sync;
    logic                   rst_n;

    // Reset is asserted asynchronously but released only on a clock edge,
    // so every flop below leaves reset in the same cycle.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // Byte enable for the next beat: byte i is valid while more than i
    // bytes of the packet remain. This is all-ones for a full beat and
    // LSB-aligned for the final, partial beat.
    always_comb begin
        keep_next = '0;
        for (int i = 0; i < BYTES; i++) begin
            keep_next[i] = (rem_q > LEN_WIDTH'(i));
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output logic. Every output is registered, so
    // nothing here reaches a port without passing through a flop.
    // A zero-length command never leaves S_IDLE. It raises busy and done
    // together, then uses zero_pend to drop busy one cycle later.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        zero_pend_d = zero_pend_q;
        guard_d     = guard_q;
        busy_d      = o_busy;
        done_d      = 1'b0;
        in_ready_d  = o_in_ready;
        enable_d    = 1'b0;
        data_d      = o_wr_data;
        keep_d      = o_wr_tkeep;
        dest_d      = o_wr_tdest;
        last_d      = o_wr_tlast;

        case (state_q)
            S_IDLE: begin
                if (zero_pend_q) begin
                    zero_pend_d = 1'b0;
                    busy_d      = 1'b0;
                end else if (i_start && !o_busy) begin
                    rem_d  = i_len_bytes;
                    dest_d = i_dest;
                    busy_d = 1'b1;
                    if (i_len_bytes == '0) begin
                        zero_pend_d = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        in_ready_d = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                if (i_in_valid && o_in_ready) begin
                    data_d     = i_in_data;
                    keep_d     = keep_next;
                    last_d     = (rem_q <= BYTES_L);
                    in_ready_d = 1'b0;
                    state_d    = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (i_wr_idle) begin
                    enable_d = 1'b1;
                    guard_d  = 1'b1;
                    state_d  = S_WAIT;
                end
            end

            S_WAIT: begin
                // The writer still reports idle in the cycle of the enable.
                // That stale idle is skipped before completion is considered.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (i_wr_idle) begin
                    rem_d = rem_q - ((rem_q >= BYTES_L) ? BYTES_L : rem_q);
                    if (o_wr_tlast) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        in_ready_d = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            zero_pend_q <= 1'b0;
            guard_q     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_in_ready  <= 1'b0;
            o_wr_enable <= 1'b0;
            o_wr_data   <= '0;
            o_wr_tkeep  <= '0;
            o_wr_tdest  <= '0;
            o_wr_tlast  <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            zero_pend_q <= zero_pend_d;
            guard_q     <= guard_d;
            o_busy      <= busy_d;
            o_done      <= done_d;
            o_in_ready  <= in_ready_d;
            o_wr_enable <= enable_d;
            o_wr_data   <= data_d;
            o_wr_tkeep  <= keep_d;
            o_wr_tdest  <= dest_d;
            o_wr_tlast  <= last_d;
        end
    end

endmodule
